// File: rtl/misr_compactor.sv
// Multiple-input signature register with a session controller: compacts scan-chain
// outputs for N_CYCLES enabled shift cycles, then latches a compare against golden.
module misr_compactor #(
    parameter int                   IN_WIDTH  = 11,
    parameter int                   SIG_WIDTH = 13,
    parameter logic [SIG_WIDTH-1:0] TAPS      = 13'h1800,
    parameter logic [SIG_WIDTH-1:0] SEED      = 13'h1070,
    parameter int                   N_CYCLES  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 test_se,
    input  logic [IN_WIDTH-1:0]  sc_out,
    input  logic [SIG_WIDTH-1:0] golden,
    output logic [SIG_WIDTH-1:0] sig,
    output logic                 busy,
    output logic                 done,
    output logic                 pass
);

    // state   | meaning
    // IDLE    | after reset, waiting for start
    // COMPACT | session running, compacting on test_se
    // DONE    | session finished, pass valid, waiting for start
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int             CW   = $clog2(N_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(N_CYCLES - 1);

    state_t               state_q, state_d;
    logic [SIG_WIDTH-1:0] sig_q, sig_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 pass_q, pass_d;

    logic [SIG_WIDTH-1:0] sc_ext;
    logic [SIG_WIDTH-1:0] sig_nxt;
    logic                 fb;

    // Chains beyond IN_WIDTH contribute nothing to the upper stages.
    always_comb begin
        sc_ext                = '0;
        sc_ext[IN_WIDTH-1:0]  = sc_out;
        fb                    = ^(sig_q & TAPS);
        sig_nxt               = {sig_q[SIG_WIDTH-2:0], fb} ^ sc_ext;
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = COMPACT;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            COMPACT: begin
                if (test_se) begin
                    sig_d = sig_nxt;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        pass_d  = (sig_nxt == golden);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign sig  = sig_q;
    assign busy = (state_q == COMPACT);
    assign done = (state_q == DONE);
    assign pass = pass_q;

endmodule
